// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer
//   Write side of the SDRAM framebuffer. Accepts a raster-ordered RGB565
//   pixel stream, packs it into aligned BURST-word bursts held in a ping-pong
//   buffer, and issues each burst to the SDRAM controller write port using
//   the same bank/row/col mapping as the scan-out reader
//   (linear = 4096*y + x; bank = x[9:8], row = {y, x[11:10]}, col = x[7:0]).
//
// Ports
//   clk, reset_n             system clock, async active-low reset
//   i_pix_valid/sof/data     pixel stream in; o_pix_ready back-pressure
//   o_wr_req/bank/row/col    burst request, held until i_wr_ack
//   i_wr_data_rd, o_wr_data  burst data, one word per strobe
//   o_frame_done             one-cycle pulse after the last burst of a frame
//
// Optional build macro FB_WR_STATS_EN adds o_burst_cnt (completed bursts,
// wrapping) and o_drop_cnt (pixels discarded by start-of-frame, saturating).
//
// FSM
//   state  | meaning
//   IDLE   | no buffer half ready for the controller
//   REQ    | o_wr_req high, address of oldest ready half on the bus
//   DATA   | streaming words of that half, one per i_wr_data_rd

module fb_pixel_writer #(
    parameter int H_RES = 1280,
    parameter int V_RES = 720,
    parameter int BURST = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_pix_valid,
    input  logic        i_pix_sof,
    input  logic [15:0] i_pix_data,
    output logic        o_pix_ready,
    output logic        o_wr_req,
    output logic [1:0]  o_wr_bank,
    output logic [11:0] o_wr_row,
    output logic [7:0]  o_wr_col,
    input  logic        i_wr_ack,
    input  logic        i_wr_data_rd,
    output logic [15:0] o_wr_data,
    output logic        o_frame_done
`ifdef FB_WR_STATS_EN
    ,
    output logic [15:0] o_burst_cnt,
    output logic [15:0] o_drop_cnt
`endif
);

    localparam int KW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]    state;
    logic          rdy_q;
    logic          done_q;
    logic [11:0]   x;
    logic [9:0]    y;
    logic          fill_sel;
    logic          drain_sel;
    logic [KW-1:0] fill_cnt;
    logic [KW-1:0] rd_k;
    logic [1:0]    full;
    logic [1:0]    last;
    logic [1:0]    bank_h [2];
    logic [11:0]   row_h  [2];
    logic [7:0]    col_h  [2];
    logic [15:0]   mem    [2][BURST];

    logic          pix_acc;
    logic          sof_acc;
    logic [KW-1:0] wr_idx;
    logic [11:0]   px;
    logic [9:0]    py;
    logic          half_done;
    logic          eol;
    logic          eof;
    logic          burst_end;
    logic [1:0]    ready_now;

    always_comb begin
        pix_acc   = i_pix_valid & o_pix_ready;
        sof_acc   = pix_acc & i_pix_sof;
        // A start-of-frame pixel restarts both the position and the fill half.
        wr_idx    = sof_acc ? '0 : fill_cnt;
        px        = sof_acc ? 12'd0 : x;
        py        = sof_acc ? 10'd0 : y;
        half_done = pix_acc && (wr_idx == KW'(BURST - 1));
        eol       = (px == 12'(H_RES - 1));
        eof       = eol && (py == 10'(V_RES - 1));
        burst_end = (state == S_DATA) && i_wr_data_rd && (rd_k == KW'(BURST - 1));
        // A half completing this cycle counts as ready so the request can
        // go out on the very next cycle.
        ready_now = full;
        if (half_done) begin
            ready_now[fill_sel] = 1'b1;
        end
    end

    assign o_pix_ready  = rdy_q & ~(full[0] & full[1]);
    assign o_wr_req     = (state == S_REQ);
    assign o_wr_bank    = bank_h[drain_sel];
    assign o_wr_row     = row_h[drain_sel];
    assign o_wr_col     = col_h[drain_sel];
    assign o_wr_data    = (state == S_DATA) ? mem[drain_sel][rd_k] : 16'd0;
    assign o_frame_done = done_q;

    // Buffer storage carries no reset; it is only observed in DATA.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            mem[fill_sel][wr_idx] <= i_pix_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            x         <= '0;
            y         <= '0;
            fill_sel  <= 1'b0;
            drain_sel <= 1'b0;
            fill_cnt  <= '0;
            rd_k      <= '0;
            full      <= '0;
            last      <= '0;
            bank_h[0] <= '0;
            bank_h[1] <= '0;
            row_h[0]  <= '0;
            row_h[1]  <= '0;
            col_h[0]  <= '0;
            col_h[1]  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            done_q <= 1'b0;

            if (pix_acc) begin
                if (wr_idx == '0) begin
                    bank_h[fill_sel] <= px[9:8];
                    row_h[fill_sel]  <= {py, px[11:10]};
                    col_h[fill_sel]  <= px[7:0];
                end
                if (eol) begin
                    x <= '0;
                    y <= (py == 10'(V_RES - 1)) ? 10'd0 : py + 10'd1;
                end else begin
                    x <= px + 12'd1;
                    y <= py;
                end
                if (half_done) begin
                    full[fill_sel] <= 1'b1;
                    last[fill_sel] <= eof;
                    fill_sel       <= ~fill_sel;
                    fill_cnt       <= '0;
                end else begin
                    fill_cnt <= wr_idx + KW'(1);
                end
            end

            // The fill half is never full, so the set above and the clear
            // below always address different halves.
            case (state)
                S_IDLE: begin
                    if (ready_now[drain_sel]) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_wr_ack) begin
                        state <= S_DATA;
                        rd_k  <= '0;
                    end
                end
                S_DATA: begin
                    if (i_wr_data_rd) begin
                        if (burst_end) begin
                            full[drain_sel] <= 1'b0;
                            done_q          <= last[drain_sel];
                            drain_sel       <= ~drain_sel;
                            rd_k            <= '0;
                            state <= ready_now[~drain_sel] ? S_REQ : S_IDLE;
                        end else begin
                            rd_k <= rd_k + KW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FB_WR_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, o_drop_cnt} + 17'(fill_cnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_burst_cnt <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (burst_end) begin
                o_burst_cnt <= o_burst_cnt + 16'd1;
            end
            if (sof_acc && (fill_cnt != '0)) begin
                o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side counterpart of the video scan-out path: accepts a raster-ordered 16-bit pixel stream from the USB/host side and writes it into the SDRAM framebuffer.
- Pixels are packed into aligned 8-word bursts and issued to the SDRAM controller's write port.
- Uses the same linear-to-bank/row/col mapping the scan-out reader uses: linear = 4096*y + x, bank = linear[9:8], row = linear[21:10], col = linear[7:0].
- Sits between the host pixel unpacker and the SDRAM controller, sharing the controller with the display reader.

Parameters:
- H_RES, 1280, active pixels per line; must be a multiple of BURST.
- V_RES, 720, active lines per frame; must be 1024 or less.
- BURST, 8, words per write burst; a power of 2 that divides 256.

Ports:
- clk  in  1  system clock, 100 MHz domain
- reset_n  in  1  asynchronous active-low reset
- i_pix_valid  in  1  pixel word valid
- i_pix_sof  in  1  start of frame; qualified by i_pix_valid
- i_pix_data  in  16  RGB565 pixel
- o_pix_ready  out  1  writer can accept a pixel
- o_wr_req  out  1  burst write request to SDRAM controller
- o_wr_bank  out  2  bank of burst
- o_wr_row  out  12  row of burst
- o_wr_col  out  8  starting column of burst
- i_wr_ack  in  1  one-cycle acceptance of request
- i_wr_data_rd  in  1  controller consumes o_wr_data this cycle
- o_wr_data  out  16  current burst word
- o_frame_done  out  1  one-cycle pulse when the last burst of a frame has been fully consumed

Behaviour:
- Reset: the asynchronous reset clears all state and takes effect immediately, including mid-burst.
  - All outputs go to 0, except o_pix_ready, which is 1 one cycle after reset_n deasserts.
  - Position counters go to (0,0); both buffer halves become empty; the FSM goes to IDLE.
- Buffering: ping-pong buffer of 2 x BURST words (fill half and drain half).
  - A pixel is accepted when i_pix_valid and o_pix_ready are both high.
  - o_pix_ready = 0 only while both halves are full.
- Position tracking:
  - Each accepted pixel advances x.
  - At x = H_RES-1, x wraps to 0 and y increments.
  - At (H_RES-1, V_RES-1), position wraps to (0,0) and the half is tagged last-of-frame.
- Start of frame: an accepted pixel with i_pix_sof is stored at (0,0).
  - Any partially filled half is discarded; its count is reset and it is never written.
  - A full half awaiting drain is unaffected.
- Half full: when a half reaches BURST words, latch bank/row/col from the (x,y) of its first word and mark the half ready.
- Address mapping: bank = x[9:8], row = {y[9:0], x[11:10]}, col = x[7:0]. Bursts are aligned, so they never cross a bank or row.
- FSM states and transitions:
  - IDLE: go to REQ when any half is ready, taking the oldest first.
  - REQ: o_wr_req = 1 with address held stable until i_wr_ack. The cycle after i_wr_ack, o_wr_req = 0 and the FSM goes to DATA.
  - DATA: o_wr_data shows word k (k starts at 0). On each i_wr_data_rd, k increments and the next word appears on the following cycle. Gaps between strobes are allowed.
  - On the BURST-th strobe: free the half; if it was last-of-frame, pulse o_frame_done on the next cycle; go to REQ if the other half is ready, else IDLE.
- i_wr_ack outside REQ is ignored; i_wr_data_rd outside DATA is ignored.
- Filling one half while draining the other in the same cycle is permitted.
- Latency: with an immediate ack, the last pixel of a half is accepted at cycle N and o_wr_req rises at N+1.

Optional Feature:
- Macro: FB_WR_STATS_EN.
- When defined, add output o_burst_cnt [15:0] and output o_drop_cnt [15:0].
  - o_burst_cnt counts completed bursts and wraps at 0xFFFF.
  - o_drop_cnt counts pixels discarded by start-of-frame and saturates at 0xFFFF.
  - Both are cleared by reset.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Stream 8 pixels 0..7 with sof on the first, controller acks immediately and reads every cycle -> one request with bank 0, row 0, col 0; data 0..7 in order; o_pix_ready stays 1.
- Write pixels up to x=256 on line y=3 -> burst for x=256..263 shows bank 1, row 12, col 0; burst for x=1024 shows bank 0, row 13, col 0.
- Hold i_wr_ack low and stream 17 pixels -> o_pix_ready drops after pixel 16; the 17th is stalled until the first burst completes.
- Send 5 pixels, then a sof pixel -> the first 5 are never written; the next burst has address (0,0); o_drop_cnt = 5 when FB_WR_STATS_EN is defined.
- Run a full 1280x720 frame with random read gaps -> 115200 bursts; single o_frame_done pulse after the final strobe; SDRAM model contents match the source.
- Assert reset_n low during DATA at k=3 -> o_wr_req = 0 and o_frame_done = 0 immediately; after release a fresh sof frame is written correctly.
